// File: rtl/xvga_timing_gen.sv
// XVGA 1024x768@60 timing generator: pixel position counters plus registered
// sync, blank and line/frame markers, all aligned to the same pixel position.
module xvga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_BLANK  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, v_wrap;

  // Decodes use the next position so they land in the same register stage
  // as the counters; with en low the next position equals the current one.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_count_d = frame_count_q;
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);

    if (en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
        if (v_wrap) begin
          frame_count_d = frame_count_q + 8'd1;
        end
      end
    end

    blank_d       = (hcount_d >= H_BLANK) || (vcount_d >= V_BLANK);
    hsync_d       = !((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST));
    vsync_d       = !((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST));
    line_start_d  = (hcount_d == 11'd0);
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 10'd0);
  end

  // Reset values describe position (0, 0) so the first frame starts cleanly.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      frame_count_q <= 8'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_count = frame_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Directed bench: a full-size XVGA instance for line-level timing and a
// shrunken-frame instance (16x10 total) for vertical, frame-wrap and width checks.
module tb_xvga_timing_gen;

  logic        vclock;
  logic        reset;
  logic        en;

  logic [10:0] d_hcount;
  logic [9:0]  d_vcount;
  logic        d_hsync, d_vsync, d_blank, d_line_start, d_frame_start;
  logic [7:0]  d_frame_count;

  logic [10:0] s_hcount;
  logic [9:0]  s_vcount;
  logic        s_hsync, s_vsync, s_blank, s_line_start, s_frame_start;
  logic [7:0]  s_frame_count;

  int checks = 0;
  int errors = 0;

  xvga_timing_gen dut (
    .vclock      (vclock),
    .reset       (reset),
    .en          (en),
    .hcount      (d_hcount),
    .vcount      (d_vcount),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .blank       (d_blank),
    .line_start  (d_line_start),
    .frame_start (d_frame_start),
    .frame_count (d_frame_count)
  );

  // Small frame: h active 0..7, hsync low 10..12, total 16;
  // v active 0..5, vsync low lines 7..8, total 10 -> 160 cycles per frame.
  xvga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_small (
    .vclock      (vclock),
    .reset       (reset),
    .en          (en),
    .hcount      (s_hcount),
    .vcount      (s_vcount),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .blank       (s_blank),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_count (s_frame_count)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge vclock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " d_hcount"}, 32'(d_hcount), 0);
    check_output({tag, " d_vcount"}, 32'(d_vcount), 0);
    check_output({tag, " d_hsync"}, 32'(d_hsync), 1);
    check_output({tag, " d_vsync"}, 32'(d_vsync), 1);
    check_output({tag, " d_blank"}, 32'(d_blank), 0);
    check_output({tag, " d_line_start"}, 32'(d_line_start), 1);
    check_output({tag, " d_frame_start"}, 32'(d_frame_start), 1);
    check_output({tag, " d_frame_count"}, 32'(d_frame_count), 0);
    check_output({tag, " s_hcount"}, 32'(s_hcount), 0);
    check_output({tag, " s_vcount"}, 32'(s_vcount), 0);
    check_output({tag, " s_frame_count"}, 32'(s_frame_count), 0);
  endtask

  initial begin
    int n;
    int hs_run;
    int vs_run;

    reset = 1'b1;
    en    = 1'b1;
    #12;
    check_reset_values("por");
    @(negedge vclock);
    reset = 1'b0;

    apply_stimulus(1);
    check_output("first hcount", 32'(d_hcount), 1);
    check_output("first line_start", 32'(d_line_start), 0);
    check_output("first frame_start", 32'(d_frame_start), 0);

    // Mid-line reset: full-size at (500,0), small at (4,1) of frame 3
    apply_stimulus(499);
    check_output("pre-reset d_hcount", 32'(d_hcount), 500);
    check_output("pre-reset s_hcount", 32'(s_hcount), 4);
    check_output("pre-reset s_vcount", 32'(s_vcount), 1);
    check_output("pre-reset s_frame_count", 32'(s_frame_count), 3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge vclock);
    reset = 1'b0;
    apply_stimulus(1);
    check_output("post-reset hcount", 32'(d_hcount), 1);

    // Horizontal decode on line 10 of the full-size instance
    apply_stimulus(14462);
    check_output("h1023 hcount", 32'(d_hcount), 1023);
    check_output("h1023 vcount", 32'(d_vcount), 10);
    check_output("h1023 blank", 32'(d_blank), 0);
    check_output("h1023 hsync", 32'(d_hsync), 1);
    apply_stimulus(1);
    check_output("h1024 blank", 32'(d_blank), 1);
    check_output("h1024 hsync", 32'(d_hsync), 1);
    apply_stimulus(23);
    check_output("h1047 hsync", 32'(d_hsync), 1);
    apply_stimulus(1);
    check_output("h1048 hcount", 32'(d_hcount), 1048);
    check_output("h1048 hsync", 32'(d_hsync), 0);
    apply_stimulus(135);
    check_output("h1183 hsync", 32'(d_hsync), 0);
    apply_stimulus(1);
    check_output("h1184 hsync", 32'(d_hsync), 1);
    apply_stimulus(159);
    check_output("h1343 hcount", 32'(d_hcount), 1343);
    check_output("h1343 line_start", 32'(d_line_start), 0);
    apply_stimulus(1);
    check_output("wrap hcount", 32'(d_hcount), 0);
    check_output("wrap vcount", 32'(d_vcount), 11);
    check_output("wrap line_start", 32'(d_line_start), 1);
    check_output("wrap frame_start", 32'(d_frame_start), 0);
    check_output("wrap blank", 32'(d_blank), 0);

    // Enable hold at (1047, 11)
    apply_stimulus(1047);
    check_output("hold pre hcount", 32'(d_hcount), 1047);
    check_output("hold pre hsync", 32'(d_hsync), 1);
    en = 1'b0;
    apply_stimulus(50);
    check_output("hold hcount", 32'(d_hcount), 1047);
    check_output("hold vcount", 32'(d_vcount), 11);
    check_output("hold hsync", 32'(d_hsync), 1);
    check_output("hold blank", 32'(d_blank), 1);
    check_output("hold line_start", 32'(d_line_start), 0);
    en = 1'b1;
    apply_stimulus(1);
    check_output("resume hcount", 32'(d_hcount), 1048);
    check_output("resume hsync", 32'(d_hsync), 0);
    check_output("resume s_hcount", 32'(s_hcount), 8);
    check_output("resume s_vcount", 32'(s_vcount), 9);
    check_output("resume s_frame_count", 32'(s_frame_count), 98);

    // Vertical decode on the small instance, frame 99
    apply_stimulus(8);
    check_output("f99 s_hcount", 32'(s_hcount), 0);
    check_output("f99 s_vcount", 32'(s_vcount), 0);
    check_output("f99 s_frame_start", 32'(s_frame_start), 1);
    check_output("f99 s_frame_count", 32'(s_frame_count), 99);
    check_output("f99 d_hcount", 32'(d_hcount), 1056);
    check_output("f99 d_hsync", 32'(d_hsync), 0);
    apply_stimulus(95);
    check_output("v5h15 blank", 32'(s_blank), 1);
    check_output("v5h15 vsync", 32'(s_vsync), 1);
    apply_stimulus(1);
    check_output("v6 vcount", 32'(s_vcount), 6);
    check_output("v6 blank", 32'(s_blank), 1);
    check_output("v6 vsync", 32'(s_vsync), 1);
    apply_stimulus(16);
    check_output("v7 vsync", 32'(s_vsync), 0);
    apply_stimulus(31);
    check_output("v8h15 vsync", 32'(s_vsync), 0);
    apply_stimulus(1);
    check_output("v9 vsync", 32'(s_vsync), 1);
    apply_stimulus(15);
    check_output("v9h15 blank", 32'(s_blank), 1);
    check_output("v9h15 frame_count", 32'(s_frame_count), 99);
    apply_stimulus(1);
    check_output("f100 frame_count", 32'(s_frame_count), 100);
    check_output("f100 frame_start", 32'(s_frame_start), 1);
    check_output("f100 blank", 32'(s_blank), 0);
    apply_stimulus(9);
    check_output("s h9 hsync", 32'(s_hsync), 1);
    check_output("s h9 blank", 32'(s_blank), 1);
    apply_stimulus(1);
    check_output("s h10 hsync", 32'(s_hsync), 0);
    apply_stimulus(2);
    check_output("s h12 hsync", 32'(s_hsync), 0);
    apply_stimulus(1);
    check_output("s h13 hsync", 32'(s_hsync), 1);

    // Frame counter wrap 255 -> 0
    apply_stimulus(24946);
    check_output("f255 s_hcount", 32'(s_hcount), 15);
    check_output("f255 s_vcount", 32'(s_vcount), 9);
    check_output("f255 frame_count", 32'(s_frame_count), 255);
    apply_stimulus(1);
    check_output("fwrap frame_count", 32'(s_frame_count), 0);
    check_output("fwrap frame_start", 32'(s_frame_start), 1);
    check_output("fwrap s_hcount", 32'(s_hcount), 0);
    check_output("fwrap s_vcount", 32'(s_vcount), 0);
    check_output("fwrap d_hcount", 32'(d_hcount), 640);
    check_output("fwrap d_vcount", 32'(d_vcount), 30);

    // Frame period between frame_start pulses, bounded
    n = 0;
    do begin
      apply_stimulus(1);
      n++;
    end while (s_frame_start !== 1'b1 && n < 400);
    check_output("frame period", 32'(n), 160);

    // Sync widths and blank region over three small frames
    hs_run = 0;
    vs_run = 0;
    for (int i = 0; i < 480; i++) begin
      apply_stimulus(1);
      check_output("blank region", 32'(s_blank),
                   32'((s_hcount >= 11'd8) || (s_vcount >= 10'd6)));
      if (s_hsync === 1'b0) begin
        hs_run++;
      end else if (hs_run > 0) begin
        check_output("hsync width", 32'(hs_run), 3);
        hs_run = 0;
      end
      if (s_vsync === 1'b0) begin
        vs_run++;
      end else if (vs_run > 0) begin
        check_output("vsync width", 32'(vs_run), 32);
        vs_run = 0;
      end
    end
    check_output("end frame_count", 32'(s_frame_count), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xvga_timing_gen.md
# xvga_timing_gen

Video timing generator for the 1024x768 @ 60 Hz XVGA mode, clocked by the 65 MHz pixel clock. It produces the pixel position (`hcount`, `vcount`), the sync and blanking signals consumed by the labkit pixel path, and frame/line markers plus a frame counter for downstream animation logic. It sits directly upstream of the top-level colour-generation and sync-synchroniser stage.

## Interface

Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch, in pixels
- `H_SYNC`, 136, horizontal sync pulse width, in pixels
- `H_BP`, 160, horizontal back porch, in pixels
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch, in lines
- `V_SYNC`, 6, vertical sync pulse width, in lines
- `V_BP`, 29, vertical back porch, in lines
- Derived values: H_TOTAL = 1344 and V_TOTAL = 806. H_TOTAL must be ≤ 2048 and V_TOTAL ≤ 1024 so the counts fit the port widths.

Ports:
- `vclock`, input, 1, 65 MHz pixel clock; all state changes on the rising edge
- `reset`, input, 1, asynchronous, active-high reset
- `en`, input, 1, pixel-advance enable; when low, all state holds
- `hcount`, output, 11, horizontal position, 0..H_TOTAL-1
- `vcount`, output, 10, vertical position, 0..V_TOTAL-1
- `hsync`, output, 1, active-low horizontal sync
- `vsync`, output, 1, active-low vertical sync
- `blank`, output, 1, high outside the visible area
- `line_start`, output, 1, high while hcount == 0
- `frame_start`, output, 1, high while hcount == 0 and vcount == 0
- `frame_count`, output, 8, count of completed frames, modulo 256

## Operation

- All outputs are registered. Every output is updated on the same edge, so within any cycle all outputs describe the same (hcount, vcount) position.
- Horizontal counter:
  - On each enabled edge, hcount increments.
  - When hcount == H_TOTAL-1 (1343), it wraps to 0.
- Vertical counter:
  - vcount increments only on the edge where hcount wraps.
  - When vcount == V_TOTAL-1 (805) at that same edge, vcount wraps to 0.
- Decodes, all evaluated on the next (hcount, vcount) value and registered together with it:
  - blank = (hcount ≥ H_ACTIVE) or (vcount ≥ V_ACTIVE).
  - hsync = 0 iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048, 1183].
  - vsync = 0 iff vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [771, 776]. vsync depends on vcount only, not on hcount.
  - line_start and frame_start follow their definitions in the port list.
- frame_count increments by 1 on the edge where (1343, 805) advances to (0, 0). It wraps from 255 to 0.
- `en` low: no counter, decode or frame_count changes. Outputs hold their exact values for as long as `en` stays low.
- Reset, asynchronous, effective immediately:
  - hcount = 0, vcount = 0, frame_count = 0
  - hsync = 1, vsync = 1, blank = 0
  - line_start = 1, frame_start = 1
- These reset values match the position (0, 0), so the first frame after reset begins with a valid frame_start.
- Reset asserted mid-frame returns all outputs to the values above at once. No partial frame is completed.

## Timing

- Latency: zero cycles from counter to decode. The decodes are computed from the next-state counters, so the sync and blank outputs are aligned to the hcount/vcount visible in the same cycle.
- Line period: 1344 enabled cycles. Frame period: 1344 × 806 = 1,083,264 enabled cycles.
- hsync is low for exactly 136 consecutive enabled cycles per line. vsync is low for exactly 6 full lines (8064 cycles) per frame.
- line_start is high for 1 cycle per line. frame_start is high for 1 cycle per frame, coincident with a line_start.
- First edge after reset deasserts, with `en` = 1: hcount = 1, line_start = 0, frame_start = 0.
- `en` toggling does not alter any count relationship; it only stretches time.
- Downstream stages must add their own pipeline delay to hsync, vsync and blank to match any delay in their pixel path.

## Test plan

- Reset: assert `reset` mid-line at (500, 300) → outputs immediately show hcount = 0, vcount = 0, hsync = 1, vsync = 1, blank = 0, line_start = 1, frame_start = 1, frame_count = 0. After release, one edge → hcount = 1.
- Horizontal decode: step through one line with vcount = 10 →
  - blank rises at hcount = 1024
  - hsync falls at 1048 and rises at 1184
  - hcount wraps 1343 → 0 with vcount 10 → 11 on the same edge, and line_start = 1 there.
- Vertical decode: run to vcount = 767 → 768 → blank stays 1 for the whole line; vsync = 0 from (0, 771) through (1343, 776); vsync = 1 at (0, 777).
- Frame wrap: from (1343, 805) with frame_count = 255 → next edge gives (0, 0), frame_start = 1, frame_count = 0. Count exactly 1,083,264 cycles between frame_start pulses.
- Enable hold: drop `en` for 50 cycles at (1047, 100) → all outputs frozen, including hsync = 1. Raise `en` → next edge gives hcount = 1048, hsync = 0.
- Sync width checker: over 3 full frames → every hsync low run is 136 cycles, every vsync low run is 8064 cycles, and blank = 0 only when hcount < 1024 and vcount < 768.
